id_reg_file_mp: RTL and testbench

//   Multi-port integer register file with a per-register scoreboard for the decode stage.

---
 rtl/id_reg_file_mp_pkg.sv | 9 +
 rtl/id_rf_wb_merge.sv | 51 +++++
 rtl/id_reg_file_mp.sv | 116 +++++++++++
 tb/tb_id_reg_file_mp.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/id_reg_file_mp_pkg.sv
// Shared constants for the decode-stage register file: default data width,
// default register count and the hard-wired zero register index.
package id_reg_file_mp_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int X0       = 0;

endpackage

// File: rtl/id_rf_wb_merge.sv
// Write-back merge: decides which lanes are accepted against the scoreboard and
// folds them into per-register write-enable, write-data and busy-clear vectors.
module id_rf_wb_merge
  import id_reg_file_mp_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREG  = NREG_DEF,
  parameter int NWB   = 2,
  parameter int TAG_W = 3,
  parameter int AW    = $clog2(NREG)
) (
  input  logic [NWB-1:0]        wb_vld,
  input  logic [NWB*AW-1:0]     wb_rd,
  input  logic [NWB*TAG_W-1:0]  wb_tag,
  input  logic [NWB*XLEN-1:0]   wb_data,
  input  logic [NREG-1:0]       busy,
  input  logic [NREG*TAG_W-1:0] tag,
  output logic [NREG-1:0]       we,
  output logic [NREG*XLEN-1:0]  wdata,
  output logic [NREG-1:0]       clr
);

  logic [NWB-1:0] accept;

  // A busy register only takes the write from the producer that currently owns it.
  always_comb begin
    accept = '0;
    for (int k = 0; k < NWB; k++) begin
      accept[k] = wb_vld[k]
                  && (wb_rd[k*AW +: AW] != AW'(X0))
                  && (!busy[wb_rd[k*AW +: AW]]
                      || (tag[wb_rd[k*AW +: AW]*TAG_W +: TAG_W] == wb_tag[k*TAG_W +: TAG_W]));
    end
  end

  // Lanes scanned in ascending order so the highest accepted lane wins the data.
  always_comb begin
    we    = '0;
    wdata = '0;
    for (int r = 1; r < NREG; r++) begin
      for (int k = 0; k < NWB; k++) begin
        if (accept[k] && (wb_rd[k*AW +: AW] == AW'(r))) begin
          we[r]                 = 1'b1;
          wdata[r*XLEN +: XLEN] = wb_data[k*XLEN +: XLEN];
        end
      end
    end
    clr = we;
  end

endmodule

// File: rtl/id_reg_file_mp.sv
// Multi-port integer register file with per-register busy/tag scoreboard,
// clocked multi-lane write-back and optional same-cycle write-back forwarding.
module id_reg_file_mp
  import id_reg_file_mp_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NRD    = 2,
  parameter int NWB    = 2,
  parameter int TAG_W  = 3,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 iss_vld,
  input  logic [AW-1:0]        iss_rd,
  input  logic [TAG_W-1:0]     iss_tag,
  input  logic [NWB-1:0]       wb_vld,
  input  logic [NWB*AW-1:0]    wb_rd,
  input  logic [NWB*TAG_W-1:0] wb_tag,
  input  logic [NWB*XLEN-1:0]  wb_data,
  input  logic                 flush
);

  logic [XLEN-1:0]       regs [1:NREG-1];
  // Entry 0 of busy/tag is never written, so x0 always reads as idle.
  logic [NREG-1:0]       busy;
  logic [NREG*TAG_W-1:0] tag;

  logic [NREG-1:0]       we;
  logic [NREG-1:0]       clr;
  logic [NREG*XLEN-1:0]  wdata;
  logic [NREG-1:0]       busy_nxt;
  logic                  tag_set;

  id_rf_wb_merge #(
    .XLEN  (XLEN),
    .NREG  (NREG),
    .NWB   (NWB),
    .TAG_W (TAG_W),
    .AW    (AW)
  ) u_merge (
    .wb_vld  (wb_vld),
    .wb_rd   (wb_rd),
    .wb_tag  (wb_tag),
    .wb_data (wb_data),
    .busy    (busy),
    .tag     (tag),
    .we      (we),
    .wdata   (wdata),
    .clr     (clr)
  );

  // Priority: flush > issue > write-back clear.
  always_comb begin
    busy_nxt = busy & ~clr;
    if (iss_vld && (iss_rd != AW'(X0))) begin
      busy_nxt[iss_rd] = 1'b1;
    end
    if (flush) begin
      busy_nxt = '0;
    end
    busy_nxt[X0] = 1'b0;
  end

  assign tag_set = iss_vld && !flush && (iss_rd != AW'(X0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 1; r < NREG; r++) begin
        regs[r] <= '0;
      end
      busy <= '0;
      tag  <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (we[r]) begin
          regs[r] <= wdata[r*XLEN +: XLEN];
        end
      end
      busy <= busy_nxt;
      if (tag_set) begin
        tag[iss_rd*TAG_W +: TAG_W] <= iss_tag;
      end
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            b;

    assign a = rd_addr[p*AW +: AW];

    always_comb begin
      d = '0;
      b = 1'b0;
      if (a != AW'(X0)) begin
        if ((BYPASS != 0) && we[a]) begin
          d = wdata[a*XLEN +: XLEN];
        end else begin
          d = regs[a];
          b = busy[a];
        end
      end
    end

    assign rd_data[p*XLEN +: XLEN] = d;
    assign rd_busy[p]              = b;
  end

endmodule

// File: tb/tb_id_reg_file_mp.sv
// Scoreboard bench for id_reg_file_mp: expected read results are queued as
// stimulus is driven and compared on the following falling edge.
module tb_id_reg_file_mp;

  localparam int XLEN  = 32;
  localparam int NRD   = 2;
  localparam int NWB   = 2;
  localparam int TAG_W = 3;
  localparam int AW    = 5;

  logic                 clk;
  logic                 rst;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic                 iss_vld;
  logic [AW-1:0]        iss_rd;
  logic [TAG_W-1:0]     iss_tag;
  logic [NWB-1:0]       wb_vld;
  logic [NWB*AW-1:0]    wb_rd;
  logic [NWB*TAG_W-1:0] wb_tag;
  logic [NWB*XLEN-1:0]  wb_data;
  logic                 flush;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    int          port;
    logic [31:0] data;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];

  id_reg_file_mp dut (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_busy (rd_busy),
    .iss_vld (iss_vld),
    .iss_rd  (iss_rd),
    .iss_tag (iss_tag),
    .wb_vld  (wb_vld),
    .wb_rd   (wb_rd),
    .wb_tag  (wb_tag),
    .wb_data (wb_data),
    .flush   (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic expect_rd(input string name, input int port, input logic [31:0] data,
                           input logic busy);
    exp_t e;
    e.name = name;
    e.port = port;
    e.data = data;
    e.busy = busy;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.name, "_data"}, rd_data[e.port*XLEN +: XLEN], e.data);
      chk({e.name, "_busy"}, {31'd0, rd_busy[e.port]}, {31'd0, e.busy});
    end
  end

  task automatic idle();
    rd_addr = '0;
    iss_vld = 1'b0;
    iss_rd  = '0;
    iss_tag = '0;
    wb_vld  = '0;
    wb_rd   = '0;
    wb_tag  = '0;
    wb_data = '0;
    flush   = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic iss(input logic [AW-1:0] r, input logic [TAG_W-1:0] t);
    iss_vld = 1'b1;
    iss_rd  = r;
    iss_tag = t;
  endtask

  task automatic wb(input int l, input logic [AW-1:0] r, input logic [TAG_W-1:0] t,
                    input logic [31:0] d);
    wb_vld[l]               = 1'b1;
    wb_rd[l*AW +: AW]       = r;
    wb_tag[l*TAG_W +: TAG_W] = t;
    wb_data[l*XLEN +: XLEN] = d;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    step(); rd(0, 5); rd(1, 7);
    expect_rd("rst_p0", 0, 32'h0, 1'b0);
    expect_rd("rst_p1", 1, 32'h0, 1'b0);

    // issue then bypassed write-back
    step(); iss(5, 3); rd(0, 5);
    expect_rd("iss_same", 0, 32'h0, 1'b0);
    step(); rd(0, 5);
    expect_rd("iss_busy", 0, 32'h0, 1'b1);
    step(); wb(0, 5, 3, 32'hDEADBEEF); rd(0, 5);
    expect_rd("wb_bypass", 0, 32'hDEADBEEF, 1'b0);
    step(); rd(0, 5);
    expect_rd("wb_array", 0, 32'hDEADBEEF, 1'b0);

    // WAW: stale producer dropped
    step(); iss(7, 1);
    step(); iss(7, 2); rd(0, 7);
    expect_rd("waw_busy", 0, 32'h0, 1'b1);
    step(); wb(0, 7, 1, 32'h11); rd(0, 7);
    expect_rd("waw_stale", 0, 32'h0, 1'b1);
    step(); wb(1, 7, 2, 32'h22); rd(1, 7);
    expect_rd("waw_good_byp", 1, 32'h22, 1'b0);
    step(); rd(0, 7);
    expect_rd("waw_good_arr", 0, 32'h22, 1'b0);

    // two lanes to one register: highest lane wins
    step(); wb(0, 9, 0, 32'hA); wb(1, 9, 0, 32'hB); rd(0, 9);
    expect_rd("dual_byp", 0, 32'hB, 1'b0);
    step(); rd(0, 9);
    expect_rd("dual_arr", 0, 32'hB, 1'b0);

    // issue overrides same-cycle busy clear, data still written
    step(); iss(4, 5); wb(0, 4, 0, 32'h44); rd(0, 4);
    expect_rd("isswb_byp", 0, 32'h44, 1'b0);
    step(); rd(0, 4);
    expect_rd("isswb_arr", 0, 32'h44, 1'b1);
    step(); wb(0, 4, 4, 32'h99); rd(0, 4);
    expect_rd("isswb_stale", 0, 32'h44, 1'b1);
    step(); wb(0, 4, 5, 32'h45); rd(0, 4);
    expect_rd("isswb_tag5", 0, 32'h45, 1'b0);

    // flush beats issue; write-back judged against pre-flush tags
    step(); iss(3, 1);
    step(); iss(6, 2);
    step(); flush = 1'b1; iss(8, 3); wb(1, 3, 7, 32'h33); rd(0, 3); rd(1, 6);
    expect_rd("fl_pre_x3", 0, 32'h0, 1'b1);
    expect_rd("fl_pre_x6", 1, 32'h0, 1'b1);
    step(); rd(0, 3); rd(1, 8);
    expect_rd("fl_x3", 0, 32'h0, 1'b0);
    expect_rd("fl_x8", 1, 32'h0, 1'b0);
    step(); wb(0, 0, 0, 32'hFF); rd(0, 0); rd(1, 6);
    expect_rd("x0_byp", 0, 32'h0, 1'b0);
    expect_rd("fl_x6", 1, 32'h0, 1'b0);
    step(); rd(0, 0);
    expect_rd("x0_arr", 0, 32'h0, 1'b0);

    // asynchronous reset mid-cycle
    step(); iss(9, 1);
    step(); rd(0, 9); rd(1, 7);
    expect_rd("pre_rst_x9", 0, 32'hB, 1'b1);
    expect_rd("pre_rst_x7", 1, 32'h22, 1'b0);
    @(posedge clk);
    #1;
    rd(0, 9); rd(1, 7);
    #2 rst = 1'b0;
    #1;
    chk("arst_p0_data", rd_data[31:0], 32'h0);
    chk("arst_p1_data", rd_data[63:32], 32'h0);
    chk("arst_busy", {30'd0, rd_busy}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    rd(0, 9); rd(1, 7);
    expect_rd("post_rst_x9", 0, 32'h0, 1'b0);
    expect_rd("post_rst_x7", 1, 32'h0, 1'b0);
    step();
    step();
    if (exp_q.size() != 0) chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
